// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and debug run-control state encodings for
//                the 5-stage MIPS fetch path.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Instruction presented to ID when the slot holds no real instruction
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Sequential PC increment in bytes
    localparam int unsigned PC_INC = 4;

    // Debug run-control states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } dbg_state_t;

endpackage
`default_nettype wire

// File: rtl/dbg_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_run_ctrl
//  Description : Debug run/halt/single-step controller. run_en is high in RUN
//                and for exactly one cycle in STEP.
//  Revision    : 1.0 - initial release
// ============================================================================
module dbg_run_ctrl
    import mips_pkg::*;
#(
    parameter bit START_HALTED = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic dbg_halt,
    input  logic dbg_step,
    input  logic dbg_resume,
    output logic run_en,
    output logic halted
);

    dbg_state_t state;
    dbg_state_t state_nx;

    // State register; the reset state selects whether the core boots running
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= START_HALTED ? ST_HALTED : ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: halt beats resume, resume beats step
    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN: begin
                if (dbg_halt) state_nx = ST_HALTED;
            end
            ST_HALTED: begin
                if (dbg_halt)        state_nx = ST_HALTED;
                else if (dbg_resume) state_nx = ST_RUN;
                else if (dbg_step)   state_nx = ST_STEP;
            end
            ST_STEP: begin
                state_nx = ST_HALTED;
            end
            default: begin
                state_nx = ST_HALTED;
            end
        endcase
    end

    assign run_en = (state == ST_RUN) || (state == ST_STEP);
    assign halted = (state == ST_HALTED);

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : IF stage of the 5-stage MIPS datapath. Owns the PC and the
//                IF/ID register, applies hazard stalls / branch redirects,
//                drives the synchronous instruction BRAM and hosts the debug
//                run-control FSM plus a fetched-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  AW           = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter bit                  START_HALTED = 1'b0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                stall_fe,
    input  logic                stall_id,
    input  logic                pc_src_id,
    input  logic [PC_WIDTH-1:0] branch_target_id,
    output logic [AW-1:0]       imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr_id,
    output logic [PC_WIDTH-1:0] pc_plus4_id,
    output logic                valid_id,
    output logic [PC_WIDTH-1:0] pc_if,
    input  logic                dbg_halt,
    input  logic                dbg_step,
    input  logic                dbg_resume,
    output logic                halted,
    output logic [31:0]         fetch_count
);

    logic                run_en;
    logic                hold_pc;
    logic                hold_id;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_seq;
    logic [PC_WIDTH-1:0] pc_plus4_q;
    // Only the BRAM word address of the ID PC is ever consumed
    logic [AW-1:0]       id_word_q;
    logic                valid_q;
    logic [31:0]         count_q;

    dbg_run_ctrl #(
        .START_HALTED (START_HALTED)
    ) u_dbg_run_ctrl (
        .clk        (clk),
        .rstn       (rstn),
        .dbg_halt   (dbg_halt),
        .dbg_step   (dbg_step),
        .dbg_resume (dbg_resume),
        .run_en     (run_en),
        .halted     (halted)
    );

    assign hold_pc = stall_fe || !run_en;
    assign hold_id = stall_id || !run_en;
    assign pc_seq  = pc_q + PC_WIDTH'(PC_INC);

    // PC register: sequential or redirected fetch unless held
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q <= RESET_PC;
        end else if (!hold_pc) begin
            pc_q <= pc_src_id ? branch_target_id : pc_seq;
        end
    end

    // IF/ID register: a taken branch squashes the fetched slot; a stall wins over the squash
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_word_q  <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (!hold_id) begin
            id_word_q  <= pc_q[AW+1:2];
            pc_plus4_q <= pc_seq;
            valid_q    <= !pc_src_id;
        end
    end

    // Count every real instruction that enters ID
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (!hold_id && !pc_src_id) begin
            count_q <= count_q + 32'd1;
        end
    end

    // Re-reading the ID word while held keeps imem_rdata stable across the stall
    assign imem_addr   = hold_id ? id_word_q : pc_q[AW+1:2];
    assign instr_id    = valid_q ? imem_rdata : NOP;
    assign pc_plus4_id = pc_plus4_q;
    assign valid_id    = valid_q;
    assign pc_if       = pc_q;
    assign fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Scoreboard bench for fetch_stage. dut_a boots running,
//                dut_b boots halted and is single-stepped.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic        a_stall_fe = 1'b0, a_stall_id = 1'b0, a_pc_src = 1'b0;
    logic [31:0] a_target = 32'h0;
    logic        a_halt = 1'b0, a_step = 1'b0, a_resume = 1'b0;
    logic [9:0]  a_addr;
    logic [31:0] a_rdata = 32'h0, a_instr, a_p4, a_pc, a_cnt;
    logic        a_valid, a_halted;

    logic        b_step = 1'b0;
    logic [9:0]  b_addr;
    logic [31:0] b_rdata = 32'h0, b_instr, b_p4, b_pc, b_cnt;
    logic        b_valid, b_halted;

    always #5 clk = ~clk;

    // BRAM models: data word encodes the word address it was read from
    always @(posedge clk) a_rdata <= 32'hC000_0000 | {22'h0, a_addr};
    always @(posedge clk) b_rdata <= 32'hC000_0000 | {22'h0, b_addr};

    fetch_stage #(.PC_WIDTH(32), .AW(10), .RESET_PC(32'h100), .START_HALTED(1'b0)) dut_a (
        .clk(clk), .rstn(rstn), .stall_fe(a_stall_fe), .stall_id(a_stall_id),
        .pc_src_id(a_pc_src), .branch_target_id(a_target), .imem_addr(a_addr),
        .imem_rdata(a_rdata), .instr_id(a_instr), .pc_plus4_id(a_p4), .valid_id(a_valid),
        .pc_if(a_pc), .dbg_halt(a_halt), .dbg_step(a_step), .dbg_resume(a_resume),
        .halted(a_halted), .fetch_count(a_cnt)
    );

    fetch_stage #(.PC_WIDTH(32), .AW(10), .RESET_PC(32'h100), .START_HALTED(1'b1)) dut_b (
        .clk(clk), .rstn(rstn), .stall_fe(1'b0), .stall_id(1'b0),
        .pc_src_id(1'b0), .branch_target_id(32'h0), .imem_addr(b_addr),
        .imem_rdata(b_rdata), .instr_id(b_instr), .pc_plus4_id(b_p4), .valid_id(b_valid),
        .pc_if(b_pc), .dbg_halt(1'b0), .dbg_step(b_step), .dbg_resume(1'b0),
        .halted(b_halted), .fetch_count(b_cnt)
    );

    typedef struct {
        string       name;
        logic [31:0] pc, p4, instr, cnt;
        logic        valid, hlt, chk_addr;
        logic [9:0]  addr;
        logic [31:0] b_pc, b_cnt;
        logic        b_hlt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, compared at the falling edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.name, "/pc_if"},       a_pc,       mon_e.pc);
            check({mon_e.name, "/pc_plus4_id"}, a_p4,       mon_e.p4);
            check({mon_e.name, "/valid_id"},    {31'h0, a_valid},  {31'h0, mon_e.valid});
            check({mon_e.name, "/instr_id"},    a_instr,    mon_e.instr);
            check({mon_e.name, "/fetch_count"}, a_cnt,      mon_e.cnt);
            check({mon_e.name, "/halted"},      {31'h0, a_halted}, {31'h0, mon_e.hlt});
            if (mon_e.chk_addr)
                check({mon_e.name, "/imem_addr"}, {22'h0, a_addr}, {22'h0, mon_e.addr});
            check({mon_e.name, "/b_pc_if"},     b_pc,       mon_e.b_pc);
            check({mon_e.name, "/b_halted"},    {31'h0, b_halted}, {31'h0, mon_e.b_hlt});
            check({mon_e.name, "/b_count"},     b_cnt,      mon_e.b_cnt);
        end
    end

    // Drive one cycle of stimulus and queue the state expected after the next rising edge
    task automatic cyc(input string nm,
                       input logic sfe, input logic sid, input logic psrc, input logic [31:0] tgt,
                       input logic hlt, input logic stp, input logic res, input logic bst,
                       input logic [31:0] epc, input logic [31:0] ep4, input logic ev,
                       input logic [31:0] ein, input logic [31:0] ecnt, input logic eh,
                       input logic ca, input logic [9:0] ead,
                       input logic [31:0] bpc, input logic bh, input logic [31:0] bcnt);
        exp_t e;
        a_stall_fe = sfe; a_stall_id = sid; a_pc_src = psrc; a_target = tgt;
        a_halt = hlt; a_step = stp; a_resume = res; b_step = bst;
        e.name = nm; e.pc = epc; e.p4 = ep4; e.valid = ev; e.instr = ein; e.cnt = ecnt;
        e.hlt = eh; e.chk_addr = ca; e.addr = ead; e.b_pc = bpc; e.b_hlt = bh; e.b_cnt = bcnt;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic push_reset_exp(input string nm);
        exp_t e;
        e.name = nm; e.pc = 32'h100; e.p4 = 32'h0; e.valid = 1'b0; e.instr = 32'h0; e.cnt = 32'h0;
        e.hlt = 1'b0; e.chk_addr = 1'b1; e.addr = 10'h40; e.b_pc = 32'h100; e.b_hlt = 1'b1; e.b_cnt = 32'h0;
        sb.push_back(e);
    endtask

    initial begin
        push_reset_exp("reset");
        @(negedge clk);
        #1;
        rstn = 1'b1;
        //   name          sfe sid src target        hlt stp res bst | pc            p4            v  instr          cnt  h  ca addr    | b_pc      bh  b_cnt
        cyc("free1",       0,  0,  0,  32'h0,        0,  0,  0,  0,  32'h104,      32'h104,      1, 32'hC000_0040, 1,   0, 0, 10'h0,  32'h100,  1,  0);
        cyc("free2",       0,  0,  0,  32'h0,        0,  0,  0,  1,  32'h108,      32'h108,      1, 32'hC000_0041, 2,   0, 0, 10'h0,  32'h100,  0,  0);
        cyc("free3",       0,  0,  0,  32'h0,        0,  0,  0,  0,  32'h10C,      32'h10C,      1, 32'hC000_0042, 3,   0, 0, 10'h0,  32'h104,  1,  1);
        cyc("br_1c",       0,  0,  1,  32'h1C,       0,  0,  0,  0,  32'h1C,       32'h110,      0, 32'h0,         3,   0, 0, 10'h0,  32'h104,  1,  1);
        cyc("pre_stall",   0,  0,  0,  32'h0,        0,  0,  0,  1,  32'h20,       32'h20,       1, 32'hC000_0007, 4,   0, 0, 10'h0,  32'h104,  0,  1);
        cyc("stall_a",     1,  1,  0,  32'h0,        0,  0,  0,  0,  32'h20,       32'h20,       1, 32'hC000_0007, 4,   0, 1, 10'h7,  32'h108,  1,  2);
        cyc("stall_b",     1,  1,  0,  32'h0,        0,  0,  0,  0,  32'h20,       32'h20,       1, 32'hC000_0007, 4,   0, 1, 10'h7,  32'h108,  1,  2);
        cyc("br_3c",       0,  0,  1,  32'h3C,       0,  0,  0,  0,  32'h3C,       32'h24,       0, 32'h0,         4,   0, 0, 10'h0,  32'h108,  1,  2);
        cyc("pre_br",      0,  0,  0,  32'h0,        0,  0,  0,  0,  32'h40,       32'h40,       1, 32'hC000_000F, 5,   0, 0, 10'h0,  32'h108,  1,  2);
        cyc("br_400",      0,  0,  1,  32'h400,      0,  0,  0,  0,  32'h400,      32'h44,       0, 32'h0,         5,   0, 0, 10'h0,  32'h108,  1,  2);
        cyc("after_br",    0,  0,  0,  32'h0,        0,  0,  0,  0,  32'h404,      32'h404,      1, 32'hC000_0100, 6,   0, 0, 10'h0,  32'h108,  1,  2);
        cyc("br_stall",    1,  1,  1,  32'h800,      0,  0,  0,  0,  32'h404,      32'h404,      1, 32'hC000_0100, 6,   0, 1, 10'h100, 32'h108, 1,  2);
        cyc("br_late",     0,  0,  1,  32'h800,      0,  0,  0,  0,  32'h800,      32'h408,      0, 32'h0,         6,   0, 0, 10'h0,  32'h108,  1,  2);
        cyc("after_late",  0,  0,  0,  32'h0,        0,  0,  0,  0,  32'h804,      32'h804,      1, 32'hC000_0200, 7,   0, 0, 10'h0,  32'h108,  1,  2);
        cyc("br_top",      0,  0,  1,  32'hFFFF_FFFC, 0, 0,  0,  0,  32'hFFFF_FFFC, 32'h808,     0, 32'h0,         7,   0, 0, 10'h0,  32'h108,  1,  2);
        cyc("wrap",        0,  0,  0,  32'h0,        0,  0,  0,  0,  32'h0,        32'h0,        1, 32'hC000_03FF, 8,   0, 0, 10'h0,  32'h108,  1,  2);
        cyc("post_wrap",   0,  0,  0,  32'h0,        0,  0,  0,  0,  32'h4,        32'h4,        1, 32'hC000_0000, 9,   0, 0, 10'h0,  32'h108,  1,  2);
        cyc("stall_fe",    1,  0,  0,  32'h0,        0,  0,  0,  0,  32'h4,        32'h8,        1, 32'hC000_0001, 10,  0, 1, 10'h1,  32'h108,  1,  2);
        cyc("halt_resume", 0,  0,  0,  32'h0,        1,  0,  1,  0,  32'h8,        32'h8,        1, 32'hC000_0001, 11,  1, 0, 10'h0,  32'h108,  1,  2);
        cyc("halted_idle", 0,  0,  0,  32'h0,        0,  0,  0,  0,  32'h8,        32'h8,        1, 32'hC000_0001, 11,  1, 1, 10'h1,  32'h108,  1,  2);
        cyc("step_resume", 0,  0,  0,  32'h0,        0,  1,  1,  0,  32'h8,        32'h8,        1, 32'hC000_0001, 11,  0, 0, 10'h0,  32'h108,  1,  2);
        cyc("step_in_run", 0,  0,  0,  32'h0,        0,  1,  0,  0,  32'hC,        32'hC,        1, 32'hC000_0002, 12,  0, 0, 10'h0,  32'h108,  1,  2);

        // Asynchronous reset in the middle of a cycle must take effect at once
        a_stall_fe = 1'b0; a_stall_id = 1'b0; a_pc_src = 1'b0; a_target = 32'h0;
        a_halt = 1'b0; a_step = 1'b0; a_resume = 1'b0; b_step = 1'b0;
        rstn = 1'b0;
        #1;
        check("async_rst/pc_if",       a_pc,               32'h100);
        check("async_rst/valid_id",    {31'h0, a_valid},   32'h0);
        check("async_rst/instr_id",    a_instr,            32'h0);
        check("async_rst/fetch_count", a_cnt,              32'h0);
        check("async_rst/b_halted",    {31'h0, b_halted},  32'h1);
        push_reset_exp("mid_reset");
        @(negedge clk);
        #1;
        rstn = 1'b1;
        cyc("post_reset",  0,  0,  0,  32'h0,        0,  0,  0,  0,  32'h104,      32'h104,      1, 32'hC000_0040, 1,   0, 0, 10'h0,  32'h100,  1,  0);

        check("scoreboard_drained", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
